// File: rtl/slot_game_ctrl_if.sv
// Ledger request/acknowledge link between the game sequencer and the bank.
interface slot_game_ctrl_if #(
  parameter int unsigned AMT_W = 11
);
  logic             txn_req;
  logic             txn_credit;
  logic [AMT_W-1:0] txn_amt;
  logic             txn_ack;

  modport master (output txn_req, output txn_credit, output txn_amt, input txn_ack);
  modport slave  (input txn_req, input txn_credit, input txn_amt, output txn_ack);
endinterface

// File: rtl/slot_game_ctrl.sv
// Per-game slot machine sequencer: latch bet, debit, spin, settle, evaluate, credit jackpot.
module slot_game_ctrl #(
  parameter int unsigned SPIN_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned PAYOUT_MULT   = 10,
  parameter int unsigned BAL_W         = 27,
  parameter int unsigned AMT_W         = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spin,
  input  logic                 b1,
  input  logic                 b10,
  input  logic                 b50,
  input  logic                 b100,
  input  logic [3:0]           randNum1,
  input  logic [3:0]           randNum2,
  input  logic [3:0]           randNum3,
  input  logic [3:0]           randNum4,
  input  logic [BAL_W-1:0]     balance,
  slot_game_ctrl_if.master     ledger,
  output logic                 reel_en,
  output logic                 busy,
  output logic                 win,
  output logic                 lose,
  output logic                 no_funds,
  output logic [15:0]          games
);

  localparam int unsigned CNT_MAX = (SPIN_CYCLES > SETTLE_CYCLES) ? SPIN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DEBIT, S_SPIN, S_SETTLE, S_EVAL, S_CREDIT, S_DONE
  } state_t;

  state_t           r_state;
  logic             r_spin_d;
  logic [6:0]       r_bet;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_d1, r_d2, r_d3, r_d4;
  logic             r_jackpot;

  logic             w_spin_edge;
  logic [6:0]       w_bet_sel;
  logic [AMT_W-1:0] w_payout;

  assign w_spin_edge = spin & ~r_spin_d;
  assign w_payout    = AMT_W'(r_bet) * AMT_W'(PAYOUT_MULT);

  always_comb begin
    w_bet_sel = '0;
    if (b100)     w_bet_sel = 7'd100;
    else if (b50) w_bet_sel = 7'd50;
    else if (b10) w_bet_sel = 7'd10;
    else if (b1)  w_bet_sel = 7'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_spin_d          <= 1'b0;
      r_bet             <= '0;
      r_cnt             <= '0;
      r_d1              <= '0;
      r_d2              <= '0;
      r_d3              <= '0;
      r_d4              <= '0;
      r_jackpot         <= 1'b0;
      ledger.txn_req    <= 1'b0;
      ledger.txn_credit <= 1'b0;
      ledger.txn_amt    <= '0;
      reel_en           <= 1'b0;
      busy              <= 1'b0;
      win               <= 1'b0;
      lose              <= 1'b0;
      no_funds          <= 1'b0;
      games             <= '0;
    end else begin
      r_spin_d <= spin;
      no_funds <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_spin_edge && (w_bet_sel != '0)) begin
            r_bet   <= w_bet_sel;
            busy    <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (balance < BAL_W'(r_bet)) begin
            no_funds <= 1'b1;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            ledger.txn_req    <= 1'b1;
            ledger.txn_credit <= 1'b0;
            ledger.txn_amt    <= AMT_W'(r_bet);
            r_state           <= S_DEBIT;
          end
        end
        S_DEBIT: begin
          if (ledger.txn_ack) begin
            ledger.txn_req <= 1'b0;
            reel_en        <= 1'b1;
            r_cnt          <= '0;
            r_state        <= S_SPIN;
          end
        end
        S_SPIN: begin
          // reel_en was raised on entry, so dropping it at count SPIN_CYCLES-1 gives exactly SPIN_CYCLES high cycles
          if (r_cnt == CNT_W'(SPIN_CYCLES - 1)) begin
            reel_en <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_d1    <= randNum1;
            r_d2    <= randNum2;
            r_d3    <= randNum3;
            r_d4    <= randNum4;
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EVAL: begin
          if ((r_d1 == r_d2) && (r_d2 == r_d3) && (r_d3 == r_d4)) begin
            r_jackpot         <= 1'b1;
            ledger.txn_req    <= 1'b1;
            ledger.txn_credit <= 1'b1;
            ledger.txn_amt    <= w_payout;
            r_state           <= S_CREDIT;
          end else begin
            r_jackpot <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_CREDIT: begin
          if (ledger.txn_ack) begin
            ledger.txn_req <= 1'b0;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          win     <= r_jackpot;
          lose    <= ~r_jackpot;
          games   <= games + 16'd1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed bench for slot_game_ctrl with a hand-driven bank acknowledge.
module tb_slot_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        spin;
  logic        b1, b10, b50, b100;
  logic [3:0]  randNum1, randNum2, randNum3, randNum4;
  logic [26:0] balance;
  logic        reel_en, busy, win, lose, no_funds;
  logic [15:0] games;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned exp_games = 0;

  slot_game_ctrl_if #(.AMT_W(11)) led ();

  slot_game_ctrl #(
    .SPIN_CYCLES  (1000),
    .SETTLE_CYCLES(4),
    .PAYOUT_MULT  (10),
    .BAL_W        (27),
    .AMT_W        (11)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .spin    (spin),
    .b1      (b1),
    .b10     (b10),
    .b50     (b50),
    .b100    (b100),
    .randNum1(randNum1),
    .randNum2(randNum2),
    .randNum3(randNum3),
    .randNum4(randNum4),
    .balance (balance),
    .ledger  (led.master),
    .reel_en (reel_en),
    .busy    (busy),
    .win     (win),
    .lose    (lose),
    .no_funds(no_funds),
    .games   (games)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full game. sw = {b100,b50,b10,b1}; dg = {randNum1..randNum4}.
  task automatic play(input int unsigned bal, input logic [3:0] sw, input logic [15:0] dg,
                      input int unsigned exp_bet, input bit exp_jp, input bit pulse, input bit abort);
    int unsigned n;
    balance = 27'(bal);
    {b100, b50, b10, b1} = sw;
    {randNum1, randNum2, randNum3, randNum4} = dg;
    spin = 1'b0;
    tick;
    spin = 1'b1;
    tick;
    chk("lat1_req", led.txn_req, 0);
    chk("lat1_busy", busy, 1);
    tick;
    chk("debit_req", led.txn_req, 1);
    chk("debit_credit", led.txn_credit, 0);
    chk("debit_amt", led.txn_amt, exp_bet);
    {b100, b50, b10, b1} = 4'b0000;
    repeat (3) tick;
    chk("debit_hold", led.txn_req, 1);
    chk("debit_amt_stable", led.txn_amt, exp_bet);
    led.txn_ack = 1'b1;
    tick;
    led.txn_ack = 1'b0;
    chk("debit_drop", led.txn_req, 0);
    n = 0;
    while (reel_en && n < 5000) begin
      n++;
      if (pulse && n == 500) spin = 1'b0;
      if (pulse && n == 501) spin = 1'b1;
      tick;
    end
    chk("spin_len", n, 1000);
    n = 0;
    while (busy && !led.txn_req && n < 100) begin
      n++;
      tick;
    end
    if (exp_jp) begin
      chk("credit_req", led.txn_req, 1);
      chk("credit_dir", led.txn_credit, 1);
      chk("credit_amt", led.txn_amt, exp_bet * 10);
      if (abort) begin
        #3 rst = 1'b0;
        #1;
        chk("abort_req", led.txn_req, 0);
        chk("abort_busy", busy, 0);
        spin = 1'b0;
        tick;
        rst = 1'b1;
        repeat (3) tick;
        chk("abort_idle", busy, 0);
        chk("abort_games", games, 0);
        chk("abort_noreq", led.txn_req, 0);
        exp_games = 0;
        return;
      end
      repeat (2) tick;
      chk("credit_hold", led.txn_req, 1);
      led.txn_ack = 1'b1;
      tick;
      led.txn_ack = 1'b0;
      chk("credit_drop", led.txn_req, 0);
    end else begin
      chk("no_credit", led.txn_req, 0);
    end
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick;
    end
    chk("done_busy", busy, 0);
    exp_games++;
    chk("win", win, exp_jp);
    chk("lose", lose, !exp_jp);
    chk("games", games, exp_games);
  endtask

  initial begin
    int unsigned busy_cnt;
    rst = 1'b0;
    spin = 1'b0;
    {b100, b50, b10, b1} = 4'b0000;
    {randNum1, randNum2, randNum3, randNum4} = '0;
    balance = '0;
    led.txn_ack = 1'b0;
    #12;
    chk("rst_req", led.txn_req, 0);
    chk("rst_outs", {reel_en, busy, win, lose, no_funds, led.txn_credit}, 0);
    chk("rst_amt", led.txn_amt, 0);
    chk("rst_games", games, 0);
    tick;
    rst = 1'b1;
    tick;
    chk("post_rst_busy", busy, 0);

    // Spin with no bet switch set does nothing
    spin = 1'b1;
    repeat (3) tick;
    chk("nobet_busy", busy, 0);
    spin = 1'b0;
    tick;

    play(100, 4'b0010, 16'h3333, 10, 1'b1, 1'b0, 1'b0);
    play(100, 4'b1001, 16'h1234, 100, 1'b0, 1'b0, 1'b0);

    // Insufficient funds
    balance = 27'd5;
    b10 = 1'b1;
    spin = 1'b0;
    tick;
    spin = 1'b1;
    tick;
    chk("nf_check_busy", busy, 1);
    tick;
    chk("nf_pulse", no_funds, 1);
    chk("nf_busy", busy, 0);
    chk("nf_req", led.txn_req, 0);
    tick;
    chk("nf_pulse_end", no_funds, 0);
    chk("nf_games", games, exp_games);

    play(10, 4'b0010, 16'h5567, 10, 1'b0, 1'b0, 1'b0);

    // Spin held high through the game and beyond, with a pulse during SPIN
    play(100, 4'b0100, 16'h9998, 50, 1'b0, 1'b1, 1'b0);
    {b100, b50, b10, b1} = 4'b0100;
    busy_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      tick;
      if (busy) busy_cnt++;
    end
    chk("held_no_restart", busy_cnt, 0);
    chk("held_games", games, exp_games);
    spin = 1'b0;
    {b100, b50, b10, b1} = 4'b0000;
    tick;

    play(100, 4'b0010, 16'h4444, 10, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
